// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/update control unit for the 4-bit teaching computer.
//
// Ports:
//   CLK, RESET_N          clock (rising edge), asynchronous active-low reset
//   PC                    current program counter value
//   IMEM_ADDR/REQ/ACK/DATA instruction fetch handshake
//   Z, N                  ALU status, sampled at the end of EXECUTE
//   DA, AA, BA, MB, CONST, FS, MD, RW   register-file / ALU controls
//   PC_STEP, PL, JB, BC, ADDR, LADDR, RADDR  single-cycle PC update controls
//   HALTED, FAULT         terminal status flags
//
// Every control output is a register loaded on the edge that enters the state
// in which it is meant to be visible, so each state shows its own controls.
module instr_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned TO_WIDTH    = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [3:0]  PC,
  output logic [3:0]  IMEM_ADDR,
  output logic        IMEM_REQ,
  input  logic        IMEM_ACK,
  input  logic [11:0] IMEM_DATA,
  input  logic        Z,
  input  logic        N,
  output logic [1:0]  DA,
  output logic [1:0]  AA,
  output logic [1:0]  BA,
  output logic        MB,
  output logic [3:0]  CONST,
  output logic [3:0]  FS,
  output logic        MD,
  output logic        RW,
  output logic        PC_STEP,
  output logic        PL,
  output logic        JB,
  output logic        BC,
  output logic [3:0]  ADDR,
  output logic [1:0]  LADDR,
  output logic [1:0]  RADDR,
  output logic        HALTED,
  output logic        FAULT
);

  typedef enum logic [2:0] {
    StIdle, StFetch, StDecode, StExecute, StUpdate, StHalt, StFault
  } state_e;

  state_e              state_q;
  logic [11:0]         iw_q;
  logic [TO_WIDTH-1:0] to_cnt_q;
  logic [TO_WIDTH-1:0] to_next;
  logic [3:0]          op;
  logic                unused_iw;

  assign op        = iw_q[11:8];
  assign to_next   = to_cnt_q + TO_WIDTH'(1);
  assign unused_iw = ^iw_q[1:0];

  // PC only moves on PC_STEP, so the live PC is the fetch address while requesting.
  assign IMEM_ADDR = IMEM_REQ ? PC : 4'h0;

  // Taken branches always use the offset-add path, so no condition select is needed.
  assign BC = 1'b0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      iw_q     <= '0;
      to_cnt_q <= '0;
      IMEM_REQ <= 1'b0;
      DA       <= '0;
      AA       <= '0;
      BA       <= '0;
      CONST    <= '0;
      MB       <= 1'b0;
      FS       <= '0;
      MD       <= 1'b0;
      RW       <= 1'b0;
      PC_STEP  <= 1'b0;
      PL       <= 1'b0;
      JB       <= 1'b0;
      ADDR     <= '0;
      LADDR    <= '0;
      RADDR    <= '0;
      HALTED   <= 1'b0;
      FAULT    <= 1'b0;
    end else begin
      // Execute and update controls are single-cycle; clear them unless reloaded.
      MB      <= 1'b0;
      FS      <= '0;
      MD      <= 1'b0;
      RW      <= 1'b0;
      PC_STEP <= 1'b0;
      PL      <= 1'b0;
      JB      <= 1'b0;
      ADDR    <= '0;
      LADDR   <= '0;
      RADDR   <= '0;

      case (state_q)
        StIdle: begin
          IMEM_REQ <= 1'b1;
          state_q  <= StFetch;
        end

        StFetch: begin
          if (IMEM_ACK) begin
            // ACK wins even on the cycle the timeout would expire.
            iw_q     <= IMEM_DATA;
            to_cnt_q <= '0;
            IMEM_REQ <= 1'b0;
            DA       <= IMEM_DATA[7:6];
            AA       <= IMEM_DATA[5:4];
            BA       <= IMEM_DATA[3:2];
            CONST    <= {2'b00, IMEM_DATA[3:2]};
            state_q  <= StDecode;
          end else if (to_next == TO_WIDTH'(ACK_TIMEOUT)) begin
            to_cnt_q <= to_next;
            IMEM_REQ <= 1'b0;
            FAULT    <= 1'b1;
            state_q  <= StFault;
          end else begin
            to_cnt_q <= to_next;
          end
        end

        StDecode: begin
          case (op)
            4'hD, 4'hE: begin
              FAULT   <= 1'b1;
              state_q <= StFault;
            end
            4'hF: begin
              HALTED  <= 1'b1;
              state_q <= StHalt;
            end
            default: begin
              state_q <= StExecute;
              case (op)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                  FS <= op;
                  RW <= 1'b1;
                end
                4'h8: begin
                  MB <= 1'b1;
                  FS <= 4'h1;  // pass B so the constant lands in DR
                  RW <= 1'b1;
                end
                4'h9: begin
                  MD <= 1'b1;
                  RW <= 1'b1;
                end
                default: ;  // NOP and control-flow ops write nothing
              endcase
            end
          endcase
        end

        StExecute: begin
          PC_STEP <= 1'b1;
          state_q <= StUpdate;
          if (op == 4'hA) begin
            PL   <= 1'b1;
            JB   <= 1'b1;
            ADDR <= iw_q[5:2];
          end else if ((op == 4'hB && Z) || (op == 4'hC && N)) begin
            PL    <= 1'b1;
            LADDR <= iw_q[7:6];
            RADDR <= iw_q[3:2];
          end
        end

        StUpdate: begin
          IMEM_REQ <= 1'b1;
          state_q  <= StFetch;
        end

        StHalt:  state_q <= StHalt;
        StFault: state_q <= StFault;
        default: begin
          FAULT   <= 1'b1;
          state_q <= StFault;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: expected PC-update records are queued
// when an instruction is handed to the DUT and checked when PC_STEP appears.
module tb_instr_sequencer;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [3:0]  pc = 4'h0;
  logic [3:0]  IMEM_ADDR;
  logic        IMEM_REQ;
  logic        IMEM_ACK = 1'b0;
  logic [11:0] IMEM_DATA = '0;
  logic        Z = 1'b0;
  logic        N = 1'b0;
  logic [1:0]  DA, AA, BA, LADDR, RADDR;
  logic        MB, MD, RW, PC_STEP, PL, JB, BC, HALTED, FAULT;
  logic [3:0]  CONST, FS, ADDR;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       pl;
    logic       jb;
    logic [3:0] addr;
    logic [1:0] laddr;
    logic [1:0] raddr;
    logic [3:0] next_pc;
  } upd_t;

  upd_t sb[$];

  instr_sequencer #(.ACK_TIMEOUT(15), .TO_WIDTH(4)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .PC(pc), .IMEM_ADDR(IMEM_ADDR), .IMEM_REQ(IMEM_REQ),
    .IMEM_ACK(IMEM_ACK), .IMEM_DATA(IMEM_DATA), .Z(Z), .N(N), .DA(DA), .AA(AA), .BA(BA),
    .MB(MB), .CONST(CONST), .FS(FS), .MD(MD), .RW(RW), .PC_STEP(PC_STEP), .PL(PL),
    .JB(JB), .BC(BC), .ADDR(ADDR), .LADDR(LADDR), .RADDR(RADDR), .HALTED(HALTED),
    .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, {11'd0, IMEM_REQ}, 12'd0);
    chk({tag, "_addr"}, {8'd0, IMEM_ADDR}, 12'd0);
    chk({tag, "_regs"}, {6'd0, DA, AA, BA}, 12'd0);
    chk({tag, "_alu"}, {2'd0, MB, CONST, FS, MD}, 12'd0);
    chk({tag, "_strobes"}, {9'd0, RW, PC_STEP, PL}, 12'd0);
    chk({tag, "_pcctl"}, {1'b0, JB, BC, ADDR, LADDR, RADDR}, 12'd0);
    chk({tag, "_flags"}, {10'd0, HALTED, FAULT}, 12'd0);
  endtask

  // Hold reset across an edge, check the cleared state, release on a falling edge.
  task automatic do_reset();
    RESET_N   = 1'b0;
    IMEM_ACK  = 1'b0;
    Z         = 1'b0;
    N         = 1'b0;
    sb.delete();
    @(negedge CLK);
    chk_all_zero("reset");
    RESET_N = 1'b1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 10 && !IMEM_REQ; i++) @(negedge CLK);
    chk("fetch_req", {11'd0, IMEM_REQ}, 12'd1);
  endtask

  // One instruction: fetch (after `delay` ACK-less cycles), decode, execute, update.
  task automatic do_instr(input logic [11:0] w, input logic z, input logic n,
                          input int delay, input bit abort_exec);
    logic [3:0] op;
    logic [3:0] exp_fs;
    logic       exp_rw;
    upd_t       e;
    upd_t       got;
    op = w[11:8];
    if (!IMEM_REQ) @(negedge CLK);
    wait_req();
    chk("fetch_addr", {8'd0, IMEM_ADDR}, {8'd0, pc});
    for (int i = 0; i < delay; i++) @(negedge CLK);
    chk("fetch_wait_req", {10'd0, IMEM_REQ, FAULT}, 12'b10);
    IMEM_DATA = w;
    IMEM_ACK  = 1'b1;
    @(negedge CLK);
    IMEM_ACK  = 1'b0;
    chk("decode_regs", {6'd0, DA, AA, BA}, {6'd0, w[7:6], w[5:4], w[3:2]});
    chk("decode_const", {8'd0, CONST}, {10'd0, w[3:2]});
    chk("decode_req", {11'd0, IMEM_REQ}, 12'd0);

    if (op == 4'hD || op == 4'hE || op == 4'hF) begin
      @(negedge CLK);
      chk("term_flags", {10'd0, HALTED, FAULT}, (op == 4'hF) ? 12'b10 : 12'b01);
      chk("term_strobes", {9'd0, IMEM_REQ, PC_STEP, RW}, 12'd0);
      return;
    end

    // Reference decode of the execute controls and the PC update.
    exp_rw = (op >= 4'h1 && op <= 4'h9);
    exp_fs = (op >= 4'h1 && op <= 4'h7) ? op : (op == 4'h8) ? 4'h1 : 4'h0;
    e = '{pl: 1'b0, jb: 1'b0, addr: 4'h0, laddr: 2'b00, raddr: 2'b00, next_pc: pc + 4'h1};
    if (op == 4'hA) begin
      e.pl = 1'b1; e.jb = 1'b1; e.addr = w[5:2]; e.next_pc = w[5:2];
    end else if ((op == 4'hB && z) || (op == 4'hC && n)) begin
      e.pl = 1'b1; e.laddr = w[7:6]; e.raddr = w[3:2];
      e.next_pc = pc + {w[7:6], w[3:2]};
    end
    sb.push_back(e);

    @(negedge CLK);
    chk("exec_rw_fs", {7'd0, RW, FS}, {7'd0, exp_rw, exp_fs});
    chk("exec_mb_md", {10'd0, MB, MD}, {10'd0, op == 4'h8, op == 4'h9});
    chk("exec_no_step", {11'd0, PC_STEP}, 12'd0);
    Z = z;
    N = n;
    if (abort_exec) begin
      #2 RESET_N = 1'b0;
      #1 chk("abort_rw", {11'd0, RW}, 12'd0);
      chk("abort_regs", {5'd0, IMEM_REQ, DA, AA, BA}, 12'd0);
      void'(sb.pop_back());
      return;
    end

    @(negedge CLK);
    chk("update_step", {10'd0, PC_STEP, RW}, 12'b10);
    chk("update_alu_clear", {6'd0, FS, MB, MD}, 12'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 12'd1, 12'd0);
    end else begin
      got = sb.pop_front();
      chk("update_pl_jb_bc", {9'd0, PL, JB, BC}, {9'd0, got.pl, got.jb, 1'b0});
      chk("update_addr", {4'd0, ADDR, LADDR, RADDR}, {4'd0, got.addr, got.laddr, got.raddr});
      pc = got.next_pc;  // the bench plays the program counter
    end
    Z = 1'b0;
    N = 1'b0;
    @(negedge CLK);
    chk("post_update_clear", {8'd0, PC_STEP, PL, JB, IMEM_REQ}, 12'b0001);
  endtask

  initial begin
    do_reset();
    pc = 4'h5;
    do_instr(12'h2E4, 1'b0, 1'b0, 0, 1'b0);  // ADD R3,R2,R1 at PC 5
    do_instr(12'hA1C, 1'b0, 1'b0, 0, 1'b0);  // JMP 7
    do_instr(12'hB44, 1'b1, 1'b0, 0, 1'b0);  // BRZ taken, +5
    do_instr(12'hB44, 1'b0, 1'b0, 0, 1'b0);  // BRZ not taken
    do_instr(12'hC00, 1'b0, 1'b0, 0, 1'b0);  // BRN not taken
    do_instr(12'hC00, 1'b0, 1'b1, 0, 1'b0);  // BRN taken, offset 0
    do_instr(12'hC44, 1'b1, 1'b0, 0, 1'b0);  // BRN ignores Z
    do_instr(12'h80C, 1'b0, 1'b0, 0, 1'b0);  // LDI const 3
    do_instr(12'h940, 1'b0, 1'b0, 14, 1'b0); // LD, ACK on the last allowed cycle
    do_instr(12'h000, 1'b0, 1'b0, 3, 1'b0);  // NOP
    do_instr(12'h6D8, 1'b0, 1'b0, 0, 1'b0);  // XOR
    do_instr(12'hBCC, 1'b1, 1'b0, 0, 1'b0);  // BRZ +15, wraps

    // Fetch timeout: 15 cycles without ACK ends in FAULT.
    wait_req();
    for (int i = 0; i < 14; i++) @(negedge CLK);
    chk("to_14_still_fetch", {10'd0, IMEM_REQ, FAULT}, 12'b10);
    @(negedge CLK);
    chk("to_fault", {10'd0, IMEM_REQ, FAULT}, 12'b01);
    for (int i = 0; i < 5; i++) @(negedge CLK);
    chk("to_fault_sticky", {9'd0, FAULT, PC_STEP, IMEM_REQ}, 12'b100);
    do_reset();
    pc = 4'h2;
    do_instr(12'h1E0, 1'b0, 1'b0, 0, 1'b0);  // MOV after recovery

    do_instr(12'hF00, 1'b0, 1'b0, 0, 1'b0);  // HALT
    for (int i = 0; i < 20; i++) @(negedge CLK);
    chk("halt_sticky", {9'd0, HALTED, IMEM_REQ, PC_STEP}, 12'b100);
    do_reset();

    pc = 4'h9;
    do_instr(12'hD00, 1'b0, 1'b0, 0, 1'b0);  // illegal opcode
    do_reset();

    pc = 4'h0;
    do_instr(12'h3A8, 1'b0, 1'b0, 0, 1'b1);  // SUB, reset during EXECUTE
    do_reset();
    pc = 4'h4;
    do_instr(12'h7E0, 1'b0, 1'b0, 0, 1'b0);  // NOT after abort

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
